// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command master: FSM state encoding,
// common serial-flash opcodes and a state-name helper for annotating traces.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ASSERT   = 3'd1,
      CMD      = 3'd2,
      RD       = 3'd3,
      DEASSERT = 3'd4,
      GAP      = 3'd5
   } state_t;

   localparam logic [7:0] RDID = 8'h9F;
   localparam logic [7:0] READ = 8'h03;
   localparam logic [7:0] RDSR = 8'h05;

   // Eight ASCII characters, right-justified and zero-padded on the left.
   function automatic logic [63:0] state_name(input state_t s);
      case (s)
         IDLE:     return 64'("IDLE");
         ASSERT:   return 64'("ASSERT");
         CMD:      return 64'("CMD");
         RD:       return 64'("RD");
         DEASSERT: return 64'("DEASSERT");
         GAP:      return 64'("GAP");
         default:  return 64'("UNKNOWN");
      endcase
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider. The counter runs while enabled and is synchronously
// cleared. Tick marks the last clk cycle of each SCLK half-period.
module spi_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (clr)
         cnt_next = '0;
      else if (en)
         cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_next;
   end

   assign tick = en && !clr && (cnt_reg == LAST);

endmodule

// File: rtl/spi_cmd_master.sv
// SPI master for serial flash: shifts one opcode out MSB first, then captures
// 0..MAX_RD_BITS bits from MISO. All SPI pins are driven straight from registers.
module spi_cmd_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV     = 2,
   parameter int INST_BITS   = 8,
   parameter int MAX_RD_BITS = 32,
   parameter int CPOL        = 0,
   parameter int CS_GAP      = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic [INST_BITS-1:0]               cmd,
   input  logic [$clog2(MAX_RD_BITS+1)-1:0]   rd_bits,
   output logic                               busy,
   output logic                               done,
   output logic [MAX_RD_BITS-1:0]             rd_data,
   output logic                               SPICLK,
   output logic                               SPICS_N,
   output logic                               SPIMOSI,
   input  logic                               SPIMISO
);

   localparam int RBW     = $clog2(MAX_RD_BITS + 1);
   localparam int CNT_MAX = (INST_BITS > MAX_RD_BITS) ? INST_BITS : MAX_RD_BITS;
   localparam int BCW     = $clog2(CNT_MAX + 1);
   localparam int GAP_N   = (CS_GAP < 1) ? 1 : CS_GAP;
   localparam int GCW     = $clog2(GAP_N + 1);
   localparam logic SCLK_IDLE = (CPOL != 0);
   localparam logic [RBW-1:0] RD_MAX = RBW'(MAX_RD_BITS);

   state_t                 state_reg, state_next;
   logic [BCW-1:0]         bit_cnt_reg, bit_cnt_next;
   logic [GCW-1:0]         gap_cnt_reg, gap_cnt_next;
   logic                   phase_reg, phase_next;
   logic [INST_BITS-1:0]   tx_reg, tx_next;
   logic [MAX_RD_BITS-1:0] rx_reg, rx_next;
   logic [RBW-1:0]         rd_len_reg, rd_len_next;
   logic                   sclk_reg, sclk_next;
   logic                   cs_n_reg, cs_n_next;
   logic                   mosi_reg, mosi_next;
   logic                   busy_reg, busy_next;
   logic                   done_reg, done_next;
   logic [MAX_RD_BITS-1:0] rd_data_reg, rd_data_next;

   logic                   tick;
   logic                   accept;
   logic [RBW-1:0]         rd_bits_clamped;
   logic [BCW-1:0]         bit_cnt_inc;
   logic [INST_BITS-1:0]   tx_shift;
   logic                   cmd_last;
   logic                   rd_last;
   logic                   gap_last;
   logic                   rising;

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk   (clk),
      .reset (reset),
      .en    (state_reg != IDLE),
      .clr   (accept),
      .tick  (tick)
   );

   assign accept          = (state_reg == IDLE) && start && !busy_reg;
   assign rd_bits_clamped = (rd_bits > RD_MAX) ? RD_MAX : rd_bits;
   assign bit_cnt_inc     = bit_cnt_reg + BCW'(1);
   assign tx_shift        = tx_reg << 1;
   assign cmd_last        = (bit_cnt_reg == BCW'(INST_BITS - 1));
   assign rd_last         = (bit_cnt_inc == BCW'(rd_len_reg));
   assign gap_last        = (gap_cnt_reg == GCW'(GAP_N - 1));
   // Leading edge rises in mode 0, trailing edge rises in mode 3.
   assign rising          = (phase_reg == SCLK_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (accept) state_next = ASSERT;
         ASSERT:   if (tick) state_next = CMD;
         CMD:      if (tick && phase_reg && cmd_last)
                      state_next = (rd_len_reg != '0) ? RD : DEASSERT;
         RD:       if (tick && phase_reg && rd_last) state_next = DEASSERT;
         DEASSERT: if (tick) state_next = GAP;
         GAP:      if (tick && gap_last) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      bit_cnt_next = bit_cnt_reg;
      gap_cnt_next = gap_cnt_reg;
      phase_next   = phase_reg;
      tx_next      = tx_reg;
      rx_next      = rx_reg;
      rd_len_next  = rd_len_reg;
      sclk_next    = sclk_reg;
      cs_n_next    = cs_n_reg;
      mosi_next    = mosi_reg;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      rd_data_next = rd_data_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               tx_next      = cmd;
               rx_next      = '0;
               rd_len_next  = rd_bits_clamped;
               cs_n_next    = 1'b0;
               mosi_next    = cmd[INST_BITS-1];
               sclk_next    = SCLK_IDLE;
               busy_next    = 1'b1;
               bit_cnt_next = '0;
               gap_cnt_next = '0;
               phase_next   = 1'b0;
            end
         end
         CMD: begin
            if (tick) begin
               if (!phase_reg) begin
                  sclk_next  = ~SCLK_IDLE;
                  phase_next = 1'b1;
               end else begin
                  sclk_next  = SCLK_IDLE;
                  phase_next = 1'b0;
                  tx_next    = tx_shift;
                  if (cmd_last) begin
                     bit_cnt_next = '0;
                     mosi_next    = 1'b0;
                  end else begin
                     bit_cnt_next = bit_cnt_inc;
                     mosi_next    = tx_shift[INST_BITS-1];
                  end
               end
            end
         end
         RD: begin
            mosi_next = 1'b0;
            if (tick) begin
               if (rising)
                  rx_next = (rx_reg << 1) | MAX_RD_BITS'(SPIMISO);
               sclk_next  = phase_reg ? SCLK_IDLE : ~SCLK_IDLE;
               phase_next = ~phase_reg;
               if (phase_reg)
                  bit_cnt_next = rd_last ? '0 : bit_cnt_inc;
            end
         end
         DEASSERT: begin
            if (tick) begin
               cs_n_next    = 1'b1;
               done_next    = 1'b1;
               rd_data_next = rx_reg;
            end
         end
         GAP: begin
            if (tick) begin
               if (gap_last) begin
                  busy_next    = 1'b0;
                  gap_cnt_next = '0;
               end else begin
                  gap_cnt_next = gap_cnt_reg + GCW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt_reg <= '0;
         gap_cnt_reg <= '0;
         phase_reg   <= 1'b0;
         tx_reg      <= '0;
         rx_reg      <= '0;
         rd_len_reg  <= '0;
         sclk_reg    <= SCLK_IDLE;
         cs_n_reg    <= 1'b1;
         mosi_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         rd_data_reg <= '0;
      end else begin
         bit_cnt_reg <= bit_cnt_next;
         gap_cnt_reg <= gap_cnt_next;
         phase_reg   <= phase_next;
         tx_reg      <= tx_next;
         rx_reg      <= rx_next;
         rd_len_reg  <= rd_len_next;
         sclk_reg    <= sclk_next;
         cs_n_reg    <= cs_n_next;
         mosi_reg    <= mosi_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         rd_data_reg <= rd_data_next;
      end
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign rd_data = rd_data_reg;
   assign SPICLK  = sclk_reg;
   assign SPICS_N = cs_n_reg;
   assign SPIMOSI = mosi_reg;

endmodule
